online_sd_adder_serial: RTL and testbench

- Digit-serial, MSD-first, radix-2 online adder for signed-digit (plus/minus encoded) operands.
- Processes LANES independent channels in lockstep, one digit per lane per accepted beat.
- Online delay is 2. Each NDIG-digit word yields NDIG+2 output digits.
- Sits between the online multiplier's digit streams and downstream online operators; it replaces fixed-width parallel signed-digit adders where streaming is needed.

---
 rtl/online_sd_adder_serial.sv | 97 +++++++++
 tb/tb_online_sd_adder_serial.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/online_sd_adder_serial.sv
// online_sd_adder_serial: digit-serial MSD-first radix-2 signed-digit online adder, online delay 2
module online_sd_adder_serial #(
  parameter int NDIG = 8,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] x_plus,
  input  logic [LANES-1:0] x_minus,
  input  logic [LANES-1:0] y_plus,
  input  logic [LANES-1:0] y_minus,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [LANES-1:0] z_plus,
  output logic [LANES-1:0] z_minus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_first,
  output logic             out_last
);
  localparam int CW = $clog2(NDIG + 1);
  typedef enum logic [1:0] {RUN, FLUSH1, FLUSH2} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LANES-1:0] u_q, u_d, r_q, r_d, z_plus_q, z_plus_d, z_minus_q, z_minus_d;
  logic out_valid_q, out_valid_d, out_first_q, out_first_d, out_last_q, out_last_d;
  logic [2:0] p [LANES];
  logic [2:0] t [LANES];
  logic [2:0] q [LANES];
  logic in_run, last_step, adv;
  assign in_run = state_q == RUN;
  assign last_step = state_q == FLUSH2;
  assign adv = !rst && (!out_valid_q || out_ready) && (!in_run || in_valid);
  assign in_ready = !rst && in_run && (!out_valid_q || out_ready);
  assign z_plus = z_plus_q;
  assign z_minus = z_minus_q;
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last = out_last_q;
  // word sequencing: count accepted digits, then two flush steps
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (adv && in_run) begin
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == CW'(NDIG - 1) ? FLUSH1 : RUN;
    end else if (adv) begin
      state_d = last_step ? RUN : FLUSH2;
      cnt_d = last_step ? '0 : cnt_q;
    end
    out_valid_d = adv || (out_valid_q && !out_ready);
    out_first_d = adv ? in_run && cnt_q == '0 : out_first_q;
    out_last_d = adv ? last_step : out_last_q;
  end
  // per-lane two-level carry-free addition; u and r are the one-step history
  always_comb begin
    u_d = u_q;
    r_d = r_q;
    z_plus_d = z_plus_q;
    z_minus_d = z_minus_q;
    for (int i = 0; i < LANES; i++) begin
      p[i] = in_run ? 3'(x_plus[i]) - 3'(x_minus[i]) + 3'(y_plus[i]) - 3'(y_minus[i]) : 3'b000;
      t[i] = (p[i] == 3'b010 || p[i] == 3'b001) ? 3'b001 : (p[i] == 3'b110) ? 3'b111 : 3'b000;
      q[i] = t[i] - 3'(u_q[i]);
      if (adv) begin
        u_d[i] = !last_step && p[i][0];
        r_d[i] = !last_step && q[i][0];
        z_plus_d[i] = r_q[i] && !q[i][2];
        z_minus_d[i] = !r_q[i] && q[i][2];
      end
    end
  end
  // state, history and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q <= '0;
      u_q <= '0;
      r_q <= '0;
      z_plus_q <= '0;
      z_minus_q <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      u_q <= u_d;
      r_q <= r_d;
      z_plus_q <= z_plus_d;
      z_minus_q <= z_minus_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q <= out_last_d;
    end
  end
endmodule

// File: tb/tb_online_sd_adder_serial.sv
// tb_online_sd_adder_serial: directed checks of the online signed-digit adder
module tb_online_sd_adder_serial;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] xp = '0, xm = '0, yp = '0, ym = '0;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic ir1, ov1, zp1, zm1, f1, l1, ir4, ov4, f4, l4;
  logic [3:0] zp4, zm4;
  int total = 0, bad = 0, hold_bad = 0, stall_bad = 0, enc_bad = 0, cyc = 0, ph = 0;
  bit stall_en = 0;
  logic prev_stall = 1'b0;
  logic [3:0] prev_e = '0;
  logic [3:0] q1[$];
  logic [7:0] q4[$];
  int ex[50][4];
  always #5 clk = ~clk;
  online_sd_adder_serial #(.NDIG(N), .LANES(1)) dut1 (
    .clk(clk), .rst(rst), .x_plus(xp[0]), .x_minus(xm[0]), .y_plus(yp[0]), .y_minus(ym[0]),
    .in_valid(in_valid), .in_ready(ir1), .z_plus(zp1), .z_minus(zm1), .out_valid(ov1),
    .out_ready(out_ready), .out_first(f1), .out_last(l1));
  online_sd_adder_serial #(.NDIG(N), .LANES(4)) dut4 (
    .clk(clk), .rst(rst), .x_plus(xp), .x_minus(xm), .y_plus(yp), .y_minus(ym),
    .in_valid(in_valid), .in_ready(ir4), .z_plus(zp4), .z_minus(zm4), .out_valid(ov4),
    .out_ready(out_ready), .out_first(f4), .out_last(l4));
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ov1 && out_ready) q1.push_back({zp1, zm1, f1, l1});
    if (ov4 && out_ready) q4.push_back({zp4, zm4});
    if ((zp1 && zm1) || |(zp4 & zm4)) enc_bad <= enc_bad + 1;
    if (prev_stall && {zp1, zm1, f1, l1} !== prev_e) hold_bad <= hold_bad + 1;
    if (ov1 && !out_ready && ir1) stall_bad <= stall_bad + 1;
    prev_stall <= ov1 && !out_ready;
    prev_e <= {zp1, zm1, f1, l1};
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (stall_en) begin
      out_ready = (ph % 3 == 0);
      ph++;
    end
  end
  function automatic int zv(input logic p, input logic m);
    return p ? 1 : (m ? -1 : 0);
  endfunction
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    xp = a; xm = b; yp = c; ym = d; in_valid = 1'b1;
    for (int n = 0; n < 100 && !ir4; n++) begin @(posedge clk); #2; end
    total++;
    if (!ir4) begin bad++; $display("FAIL send_timeout in_ready=%b expected 1", ir4); end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask
  task automatic send_word(input int xv[4], input int yv[4], input int ndig, input bit gap);
    for (int j = 0; j < ndig; j++) begin
      if (gap && j > 0) repeat ($urandom_range(1, 3)) begin
        @(posedge clk); #2;
        total++;
        if (ov1 !== 1'b0) begin bad++; $display("FAIL gap_out_valid got=%b exp=0", ov1); end
      end
      send({4{xv[j] > 0}}, {4{xv[j] < 0}}, {4{yv[j] > 0}}, {4{yv[j] < 0}});
    end
  endtask
  task automatic test_reset;
    #3;
    total++;
    if ({ov1, zp1, zm1, f1, l1, ir1} !== 6'b0) begin bad++; $display("FAIL reset_outputs got=%b exp=000000", {ov1, zp1, zm1, f1, l1, ir1}); end
    total++;
    if ({ov4, zp4, zm4, ir4} !== 10'b0) begin bad++; $display("FAIL reset_outputs4 got=%b exp=0", {ov4, zp4, zm4, ir4}); end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    total++;
    if (ir1 !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b exp=1", ir1); end
    @(posedge clk); #2;
  endtask
  task automatic test_add_one;
    int e[6] = '{0, 1, 0, 0, 0, 0};
    send_word('{1, 0, 0, 0}, '{1, 0, 0, 0}, 4, 0);
    for (int n = 0; n < 200 && q1.size() < 6; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    total++;
    if (q1.size() !== 6) begin bad++; $display("FAIL one_count got=%0d exp=6", q1.size()); end
    for (int k = 0; k < 6 && k < q1.size(); k++) begin
      total++;
      if (zv(q1[k][3], q1[k][2]) !== e[k] || q1[k][1] !== (k == 0) || q1[k][0] !== (k == 5)) begin
        bad++; $display("FAIL one_digit%0d got z=%0d f=%b l=%b exp z=%0d", k, zv(q1[k][3], q1[k][2]), q1[k][1], q1[k][0], e[k]);
      end
    end
    q1.delete(); q4.delete();
    @(posedge clk); #2;
  endtask
  task automatic test_add_neg;
    int e[6] = '{-1, 0, 0, 0, 1, 0};
    send_word('{-1, -1, -1, -1}, '{-1, -1, -1, -1}, 4, 0);
    for (int n = 0; n < 200 && q1.size() < 6; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    total++;
    if (q1.size() !== 6) begin bad++; $display("FAIL neg_count got=%0d exp=6", q1.size()); end
    for (int k = 0; k < 6 && k < q1.size(); k++) begin
      total++;
      if (zv(q1[k][3], q1[k][2]) !== e[k] || q1[k][2] !== (k == 0) || q1[k][1] !== (k == 0) || q1[k][0] !== (k == 5)) begin
        bad++; $display("FAIL neg_digit%0d got z=%0d zm=%b f=%b l=%b exp z=%0d", k, zv(q1[k][3], q1[k][2]), q1[k][2], q1[k][1], q1[k][0], e[k]);
      end
    end
    q1.delete(); q4.delete();
    @(posedge clk); #2;
  endtask
  task automatic test_stall;
    int e[6] = '{-1, 0, 0, 0, 1, 0};
    int h0 = hold_bad, s0 = stall_bad;
    ph = 0;
    stall_en = 1;
    send_word('{-1, -1, -1, -1}, '{-1, -1, -1, -1}, 4, 0);
    for (int n = 0; n < 300 && q1.size() < 6; n++) @(negedge clk);
    repeat (6) @(negedge clk);
    total++;
    if (q1.size() !== 6) begin bad++; $display("FAIL stall_count got=%0d exp=6", q1.size()); end
    for (int k = 0; k < 6 && k < q1.size(); k++) begin
      total++;
      if (zv(q1[k][3], q1[k][2]) !== e[k] || q1[k][1] !== (k == 0) || q1[k][0] !== (k == 5)) begin
        bad++; $display("FAIL stall_digit%0d got z=%0d f=%b l=%b exp z=%0d", k, zv(q1[k][3], q1[k][2]), q1[k][1], q1[k][0], e[k]);
      end
    end
    total++;
    if (hold_bad !== h0) begin bad++; $display("FAIL stall_hold got=%0d exp=%0d", hold_bad, h0); end
    total++;
    if (stall_bad !== s0) begin bad++; $display("FAIL stall_in_ready got=%0d exp=%0d", stall_bad, s0); end
    @(posedge clk); #2;
    stall_en = 0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    repeat (2) @(negedge clk);
    q1.delete(); q4.delete();
    @(posedge clk); #2;
  endtask
  task automatic test_gaps;
    int e[6] = '{-1, 0, 0, 0, 1, 0};
    send_word('{-1, -1, -1, -1}, '{-1, -1, -1, -1}, 4, 1);
    for (int n = 0; n < 200 && q1.size() < 6; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    total++;
    if (q1.size() !== 6) begin bad++; $display("FAIL gap_count got=%0d exp=6", q1.size()); end
    for (int k = 0; k < 6 && k < q1.size(); k++) begin
      total++;
      if (zv(q1[k][3], q1[k][2]) !== e[k] || q1[k][1] !== (k == 0) || q1[k][0] !== (k == 5)) begin
        bad++; $display("FAIL gap_digit%0d got z=%0d f=%b l=%b exp z=%0d", k, zv(q1[k][3], q1[k][2]), q1[k][1], q1[k][0], e[k]);
      end
    end
    total++;
    if (ov1 !== 1'b0) begin bad++; $display("FAIL gap_idle_valid got=%b exp=0", ov1); end
    q1.delete(); q4.delete();
    @(posedge clk); #2;
  endtask
  task automatic test_reset_mid;
    int e[6] = '{0, 1, 0, 0, 0, 0};
    send_word('{-1, -1, -1, -1}, '{-1, -1, -1, -1}, 3, 0);
    rst = 1'b1;
    #1;
    total++;
    if ({ov1, zp1, zm1, f1, l1, ir1} !== 6'b0) begin bad++; $display("FAIL midreset_outputs got=%b exp=000000", {ov1, zp1, zm1, f1, l1, ir1}); end
    total++;
    if ({ov4, zp4, zm4, ir4} !== 10'b0) begin bad++; $display("FAIL midreset_outputs4 got=%b exp=0", {ov4, zp4, zm4, ir4}); end
    @(posedge clk); #2;
    rst = 1'b0;
    q1.delete(); q4.delete();
    @(posedge clk); #2;
    send_word('{1, 0, 0, 0}, '{1, 0, 0, 0}, 4, 0);
    for (int n = 0; n < 200 && q1.size() < 6; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    total++;
    if (q1.size() !== 6) begin bad++; $display("FAIL midreset_count got=%0d exp=6", q1.size()); end
    for (int k = 0; k < 6 && k < q1.size(); k++) begin
      total++;
      if (zv(q1[k][3], q1[k][2]) !== e[k] || q1[k][1] !== (k == 0) || q1[k][0] !== (k == 5)) begin
        bad++; $display("FAIL midreset_digit%0d got z=%0d f=%b l=%b exp z=%0d", k, zv(q1[k][3], q1[k][2]), q1[k][1], q1[k][0], e[k]);
      end
    end
    q1.delete(); q4.delete();
    @(posedge clk); #2;
  endtask
  task automatic test_back_to_back;
    int c0, s;
    logic [3:0] a, b, c, d;
    for (int w = 0; w < 50; w++) for (int l = 0; l < 4; l++) ex[w][l] = 0;
    c0 = cyc;
    for (int w = 0; w < 50; w++) begin
      for (int j = 0; j < N; j++) begin
        a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
        c = 4'($urandom_range(0, 15)); d = 4'($urandom_range(0, 15));
        for (int l = 0; l < 4; l++)
          ex[w][l] += (int'(a[l]) - int'(b[l]) + int'(c[l]) - int'(d[l])) * (8 >> j);
        send(a, b, c, d);
      end
    end
    total++;
    if (cyc - c0 !== 298) begin bad++; $display("FAIL b2b_cycles got=%0d exp=298", cyc - c0); end
    for (int n = 0; n < 400 && q4.size() < 300; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    total++;
    if (q4.size() !== 300) begin bad++; $display("FAIL b2b_count got=%0d exp=300", q4.size()); end
    for (int w = 0; w < 50 && q4.size() >= 300; w++) begin
      for (int l = 0; l < 4; l++) begin
        s = 0;
        for (int k = 0; k < 6; k++) s += zv(q4[w * 6 + k][4 + l], q4[w * 6 + k][l]) * (32 >> k);
        total++;
        if (s !== ex[w][l]) begin bad++; $display("FAIL b2b_word%0d_lane%0d got=%0d exp=%0d (x1/16)", w, l, s, ex[w][l]); end
      end
    end
    total++;
    if (enc_bad !== 0) begin bad++; $display("FAIL out_encoding got=%0d exp=0", enc_bad); end
    q1.delete(); q4.delete();
  endtask
  initial begin
    test_reset;
    test_add_one;
    test_add_neg;
    test_stall;
    test_gaps;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
